// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch path: opcodes, IR field positions,
// fetch FSM states and next-PC selector modes.
package sisc_pkg;

    // Opcode values carried in ir[31:28]
    localparam logic [3:0] NOOP   = 4'd0;
    localparam logic [3:0] LOD    = 4'd1;
    localparam logic [3:0] STR    = 4'd2;
    localparam logic [3:0] SWP    = 4'd3;
    localparam logic [3:0] BRA    = 4'd4;
    localparam logic [3:0] BRR    = 4'd5;
    localparam logic [3:0] BNE    = 4'd6;
    localparam logic [3:0] BNR    = 4'd7;
    localparam logic [3:0] ALU_OP = 4'd8;
    localparam logic [3:0] HLT    = 4'd15;

    // Instruction register field positions (MSB of each field)
    localparam int OPC_MSB = 31;
    localparam int MM_MSB  = 27;
    localparam int IMM_MSB = 15;
    localparam int FIELD_W = 4;
    localparam int IMM_W   = 16;

    // Fetch FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_e;

    // Next-PC source selection
    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_ABS = 2'd1,
        PC_REL = 2'd2
    } pc_mode_e;

    // A fetch is requested only by the exact ir_load + pc_write + increment combination
    function automatic logic is_fetch_cmd(input logic ir_load, input logic pc_write,
                                          input logic pc_sel);
        return ir_load & pc_write & ~pc_sel;
    endfunction

    // A branch is a PC write selecting the target, without an IR load
    function automatic logic is_branch_cmd(input logic ir_load, input logic pc_write,
                                           input logic pc_sel);
        return ~ir_load & pc_write & pc_sel;
    endfunction

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and imem.
interface sisc_fetch_unit_if #(
    parameter int AW = 16,
    parameter int IW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/sisc_pc_next.sv
// Combinational next-PC selector: increment, absolute target, or PC-relative
// target. All arithmetic wraps modulo 2^AW.
module sisc_pc_next
    import sisc_pkg::*;
#(
    parameter int AW = 16
) (
    input  pc_mode_e      mode,
    input  logic [AW-1:0] pc,
    input  logic [15:0]   imm,
    output logic [AW-1:0] pc_next
);

    logic [AW-1:0] imm_ext_s;

    // The immediate is truncated or zero-extended to the PC width
    if (AW <= 16) begin : g_imm_trunc
        assign imm_ext_s = imm[AW-1:0];
    end else begin : g_imm_ext
        assign imm_ext_s = {{(AW-16){1'b0}}, imm};
    end

    // Select the next PC value according to the requested mode
    always_comb begin
        pc_next = pc + {{(AW-1){1'b0}}, 1'b1};
        case (mode)
            PC_INC:  pc_next = pc + {{(AW-1){1'b0}}, 1'b1};
            PC_ABS:  pc_next = imm_ext_s;
            PC_REL:  pc_next = pc + imm_ext_s;
            default: pc_next = pc + {{(AW-1){1'b0}}, 1'b1};
        endcase
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch responder: owns PC and IR, executes controller
// PC/IR commands, fetches from imem over req/ack with a timeout, and
// reports busy and sticky fault status.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int AW      = 16,
    parameter int IW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic                pc_rst,
    input  logic                pc_write,
    input  logic                pc_sel,
    input  logic                br_sel,
    input  logic                ir_load,
    sisc_fetch_unit_if.master   imem,
    output logic [AW-1:0]       pc,
    output logic [IW-1:0]       ir,
    output logic [3:0]          opcode,
    output logic [3:0]          mm,
    output logic [15:0]         imm,
    output logic                busy,
    output logic                fault
);

    // Counter only needs to reach TIMEOUT-1
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    fetch_state_e  state_r, state_nxt_s;
    logic [AW-1:0] pc_r, pc_nxt_s, pc_target_s;
    logic [IW-1:0] ir_r, ir_nxt_s;
    logic          req_r, req_nxt_s;
    logic [AW-1:0] addr_r, addr_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          fault_r, fault_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    pc_mode_e      pc_mode_s;
    logic [15:0]   imm_s;

    assign imm_s = ir_r[IMM_MSB -: IMM_W];

    // Choose the next-PC source from state and command inputs only
    always_comb begin
        pc_mode_s = PC_INC;
        if ((state_r == ST_IDLE) && is_branch_cmd(ir_load, pc_write, pc_sel)) begin
            pc_mode_s = br_sel ? PC_ABS : PC_REL;
        end else begin
            pc_mode_s = PC_INC;
        end
    end

    sisc_pc_next #(.AW(AW)) u_pc_next (
        .mode    (pc_mode_s),
        .pc      (pc_r),
        .imm     (imm_s),
        .pc_next (pc_target_s)
    );

    // Fetch FSM next-state and next-register values; pc_rst overrides everything
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_nxt_s    = ir_r;
        req_nxt_s   = req_r;
        addr_nxt_s  = addr_r;
        busy_nxt_s  = busy_r;
        fault_nxt_s = fault_r;
        cnt_nxt_s   = cnt_r;
        if (pc_rst) begin
            state_nxt_s = ST_IDLE;
            pc_nxt_s    = '0;
            ir_nxt_s    = '0;
            req_nxt_s   = 1'b0;
            addr_nxt_s  = '0;
            busy_nxt_s  = 1'b0;
            fault_nxt_s = 1'b0;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_fetch_cmd(ir_load, pc_write, pc_sel)) begin
                        state_nxt_s = ST_REQ;
                        req_nxt_s   = 1'b1;
                        addr_nxt_s  = pc_r;
                        busy_nxt_s  = 1'b1;
                        cnt_nxt_s   = '0;
                    end else if (is_branch_cmd(ir_load, pc_write, pc_sel)) begin
                        pc_nxt_s = pc_target_s;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end
                ST_REQ: begin
                    // Commands during a fetch are dropped but flagged
                    if (pc_write || ir_load) begin
                        fault_nxt_s = 1'b1;
                    end else begin
                        fault_nxt_s = fault_r;
                    end
                    if (imem.imem_ack) begin
                        ir_nxt_s    = imem.imem_rdata;
                        pc_nxt_s    = pc_target_s;
                        req_nxt_s   = 1'b0;
                        busy_nxt_s  = 1'b0;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end else if (cnt_r == TO_LAST) begin
                        fault_nxt_s = 1'b1;
                        req_nxt_s   = 1'b0;
                        busy_nxt_s  = 1'b0;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                    busy_nxt_s  = 1'b0;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r <= ST_IDLE;
            pc_r    <= '0;
            ir_r    <= '0;
            req_r   <= 1'b0;
            addr_r  <= '0;
            busy_r  <= 1'b0;
            fault_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            ir_r    <= ir_nxt_s;
            req_r   <= req_nxt_s;
            addr_r  <= addr_nxt_s;
            busy_r  <= busy_nxt_s;
            fault_r <= fault_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = addr_r;
    assign pc     = pc_r;
    assign ir     = ir_r;
    assign opcode = ir_r[OPC_MSB -: FIELD_W];
    assign mm     = ir_r[MM_MSB -: FIELD_W];
    assign imm    = imm_s;
    assign busy   = busy_r;
    assign fault  = fault_r;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: directed scenarios plus a
// randomized command sequence against a behavioural PC/IR/fault model.
module tb_sisc_fetch_unit;

    localparam int AW      = 16;
    localparam int IW      = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [3:0]    opcode, mm;
    logic [15:0]   imm;
    logic          busy, fault;

    sisc_fetch_unit_if #(.AW(AW), .IW(IW)) imem_bus ();

    sisc_fetch_unit #(.AW(AW), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load), .imem(imem_bus),
        .pc(pc), .ir(ir), .opcode(opcode), .mm(mm), .imm(imm),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int chk_n  = 0;
    int pass_n = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic        m_fault;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        pc_write = 1'b0; ir_load = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; pc_rst = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = 32'h0000_0000; m_fault = 1'b0;
    endtask

    // Complete fetch with a given number of non-ack cycles before the ack
    task automatic do_fetch(input logic [31:0] word, input int waits);
        ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        step();
        clear_cmds();
        repeat (waits) step();
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = word;
        step();
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = $urandom;
        m_ir = word;
        m_pc = m_pc + 16'd1;
    endtask

    task automatic do_branch(input logic absolute);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = absolute;
        step();
        clear_cmds();
        if (absolute) m_pc = m_ir[15:0];
        else          m_pc = m_pc + m_ir[15:0];
    endtask

    task automatic do_pc_rst();
        pc_rst = 1'b1;
        step();
        pc_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst_f = 1'b0; clear_cmds();
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0000_0000;
        step(); step();
        chk_n++; if (pc !== 16'h0000) $display("FAIL reset_pc got=%h want=0000", pc); else pass_n++;
        chk_n++; if (ir !== 32'h0) $display("FAIL reset_ir got=%h want=0", ir); else pass_n++;
        chk_n++; if (imem_bus.imem_req !== 1'b0) $display("FAIL reset_req got=%b want=0", imem_bus.imem_req); else pass_n++;
        chk_n++; if (imem_bus.imem_addr !== 16'h0) $display("FAIL reset_addr got=%h want=0", imem_bus.imem_addr); else pass_n++;
        chk_n++; if ({busy, fault} !== 2'b00) $display("FAIL reset_busy_fault got=%b want=00", {busy, fault}); else pass_n++;
        chk_n++; if ({opcode, mm, imm} !== 24'h0) $display("FAIL reset_fields got=%h want=0", {opcode, mm, imm}); else pass_n++;
        rst_f = 1'b1;
        model_reset();
        step();
        chk_n++; if (pc !== 16'h0000) $display("FAIL reset_release_pc got=%h want=0000", pc); else pass_n++;
    endtask

    task automatic test_fetch_zero_wait();
        ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        step();
        clear_cmds();
        chk_n++; if (busy !== 1'b1) $display("FAIL zw_busy_on got=%b want=1", busy); else pass_n++;
        chk_n++; if (imem_bus.imem_req !== 1'b1) $display("FAIL zw_req got=%b want=1", imem_bus.imem_req); else pass_n++;
        chk_n++; if (imem_bus.imem_addr !== 16'h0000) $display("FAIL zw_addr got=%h want=0000", imem_bus.imem_addr); else pass_n++;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h8412_0005;
        step();
        imem_bus.imem_ack = 1'b0;
        m_ir = 32'h8412_0005; m_pc = 16'h0001;
        chk_n++; if (ir !== 32'h8412_0005) $display("FAIL zw_ir got=%h want=84120005", ir); else pass_n++;
        chk_n++; if (opcode !== 4'd8) $display("FAIL zw_opcode got=%0d want=8", opcode); else pass_n++;
        chk_n++; if (mm !== 4'd4) $display("FAIL zw_mm got=%0d want=4", mm); else pass_n++;
        chk_n++; if (imm !== 16'h0005) $display("FAIL zw_imm got=%h want=0005", imm); else pass_n++;
        chk_n++; if (pc !== 16'h0001) $display("FAIL zw_pc got=%h want=0001", pc); else pass_n++;
        chk_n++; if (busy !== 1'b0) $display("FAIL zw_busy_off got=%b want=0", busy); else pass_n++;
    endtask

    task automatic test_wait_state();
        do_fetch(32'h0000_0010, 0);
        do_branch(1'b1);
        chk_n++; if (pc !== 16'h0010) $display("FAIL ws_setup_pc got=%h want=0010", pc); else pass_n++;
        ir_load = 1'b1; pc_write = 1'b1;
        step();
        clear_cmds();
        for (int k = 0; k < 3; k++) begin
            chk_n++; if (imem_bus.imem_addr !== 16'h0010 || imem_bus.imem_req !== 1'b1)
                $display("FAIL ws_hold%0d addr=%h req=%b want 0010/1", k, imem_bus.imem_addr, imem_bus.imem_req); else pass_n++;
            step();
        end
        chk_n++; if (imem_bus.imem_addr !== 16'h0010) $display("FAIL ws_hold3 addr=%h want=0010", imem_bus.imem_addr); else pass_n++;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1800_00AA;
        step();
        imem_bus.imem_ack = 1'b0;
        m_ir = 32'h1800_00AA; m_pc = 16'h0011;
        chk_n++; if (ir !== 32'h1800_00AA) $display("FAIL ws_ir got=%h want=180000AA", ir); else pass_n++;
        chk_n++; if (pc !== 16'h0011) $display("FAIL ws_pc got=%h want=0011", pc); else pass_n++;
    endtask

    task automatic test_branches();
        do_fetch(32'h0000_0040, 1);
        do_branch(1'b1);
        chk_n++; if (pc !== 16'h0040) $display("FAIL br_abs_pc got=%h want=0040", pc); else pass_n++;
        chk_n++; if (busy !== 1'b0) $display("FAIL br_abs_busy got=%b want=0", busy); else pass_n++;
        do_fetch(32'h0000_FFFD, 2);
        do_branch(1'b1);
        do_fetch(32'h0000_0003, 0);
        chk_n++; if (pc !== 16'hFFFE) $display("FAIL br_setup_pc got=%h want=FFFE", pc); else pass_n++;
        do_branch(1'b0);
        chk_n++; if (pc !== 16'h0001) $display("FAIL br_rel_wrap_pc got=%h want=0001", pc); else pass_n++;
        chk_n++; if (busy !== 1'b0 || imem_bus.imem_req !== 1'b0) $display("FAIL br_rel_busy busy=%b req=%b want 0/0", busy, imem_bus.imem_req); else pass_n++;
    endtask

    task automatic test_timeout();
        ir_load = 1'b1; pc_write = 1'b1;
        step();
        clear_cmds();
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            chk_n++; if (imem_bus.imem_req !== 1'b1) $display("FAIL to_req_held edge=%0d got=%b want=1", k, imem_bus.imem_req); else pass_n++;
        end
        step();
        m_fault = 1'b1;
        chk_n++; if (imem_bus.imem_req !== 1'b0 || busy !== 1'b0) $display("FAIL to_drop req=%b busy=%b want 0/0", imem_bus.imem_req, busy); else pass_n++;
        chk_n++; if (fault !== 1'b1) $display("FAIL to_fault got=%b want=1", fault); else pass_n++;
        chk_n++; if (pc !== m_pc || ir !== m_ir) $display("FAIL to_unchanged pc=%h ir=%h want %h/%h", pc, ir, m_pc, m_ir); else pass_n++;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hCAFE_F00D;
        step();
        imem_bus.imem_ack = 1'b0;
        chk_n++; if (pc !== m_pc || ir !== m_ir) $display("FAIL to_late_ack pc=%h ir=%h want %h/%h", pc, ir, m_pc, m_ir); else pass_n++;
        do_pc_rst();
        chk_n++; if (fault !== 1'b0 || pc !== 16'h0) $display("FAIL to_clear fault=%b pc=%h want 0/0000", fault, pc); else pass_n++;
    endtask

    task automatic test_cmd_while_busy();
        do_fetch(32'h0000_0123, 0);
        ir_load = 1'b1; pc_write = 1'b1;
        step();
        clear_cmds();
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
        step();
        clear_cmds();
        m_fault = 1'b1;
        chk_n++; if (fault !== 1'b1) $display("FAIL cwb_fault got=%b want=1", fault); else pass_n++;
        chk_n++; if (pc !== m_pc) $display("FAIL cwb_pc got=%h want=%h", pc, m_pc); else pass_n++;
        chk_n++; if (imem_bus.imem_req !== 1'b1) $display("FAIL cwb_req got=%b want=1", imem_bus.imem_req); else pass_n++;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h2A00_0777;
        step();
        imem_bus.imem_ack = 1'b0;
        m_ir = 32'h2A00_0777; m_pc = m_pc + 16'd1;
        chk_n++; if (ir !== m_ir || pc !== m_pc) $display("FAIL cwb_done ir=%h pc=%h want %h/%h", ir, pc, m_ir, m_pc); else pass_n++;
        chk_n++; if (fault !== 1'b1 || busy !== 1'b0) $display("FAIL cwb_sticky fault=%b busy=%b want 1/0", fault, busy); else pass_n++;
        do_pc_rst();
    endtask

    task automatic test_pc_rst_mid_fetch();
        do_fetch(32'h3300_1234, 0);
        ir_load = 1'b1; pc_write = 1'b1;
        step();
        ir_load = 1'b1; pc_write = 1'b0;
        step();
        clear_cmds();
        chk_n++; if (fault !== 1'b1) $display("FAIL prst_pre_fault got=%b want=1", fault); else pass_n++;
        pc_rst = 1'b1; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        pc_rst = 1'b0; imem_bus.imem_ack = 1'b0;
        model_reset();
        chk_n++; if (pc !== 16'h0 || ir !== 32'h0) $display("FAIL prst_pc_ir pc=%h ir=%h want 0/0", pc, ir); else pass_n++;
        chk_n++; if (imem_bus.imem_req !== 1'b0 || busy !== 1'b0) $display("FAIL prst_req req=%b busy=%b want 0/0", imem_bus.imem_req, busy); else pass_n++;
        chk_n++; if (fault !== 1'b0) $display("FAIL prst_fault got=%b want=0", fault); else pass_n++;
    endtask

    task automatic test_async_reset();
        do_fetch(32'h5500_0042, 0);
        ir_load = 1'b1; pc_write = 1'b1;
        step();
        clear_cmds();
        chk_n++; if (imem_bus.imem_req !== 1'b1) $display("FAIL ar_pre_req got=%b want=1", imem_bus.imem_req); else pass_n++;
        #2;
        rst_f = 1'b0;
        #1;
        chk_n++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 16'h0) $display("FAIL ar_bus req=%b addr=%h want 0/0", imem_bus.imem_req, imem_bus.imem_addr); else pass_n++;
        chk_n++; if (pc !== 16'h0 || ir !== 32'h0) $display("FAIL ar_pc_ir pc=%h ir=%h want 0/0", pc, ir); else pass_n++;
        chk_n++; if (busy !== 1'b0 || fault !== 1'b0) $display("FAIL ar_status busy=%b fault=%b want 0/0", busy, fault); else pass_n++;
        #2;
        rst_f = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_random();
        do_fetch($urandom, TIMEOUT - 1);
        chk_n++; if (pc !== m_pc || ir !== m_ir || fault !== 1'b0) $display("FAIL rnd_maxwait pc=%h ir=%h fault=%b want %h/%h/0", pc, ir, fault, m_pc, m_ir); else pass_n++;
        for (int n = 0; n < 60; n++) begin
            int unsigned sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1: do_fetch($urandom, int'($urandom_range(0, TIMEOUT - 1)));
                2:    do_branch(1'b1);
                3:    do_branch(1'b0);
                4: begin
                    ir_load = 1'b1; pc_write = 1'b0; pc_sel = 1'($urandom);
                    step();
                    clear_cmds();
                end
                default: begin
                    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'($urandom);
                    step();
                    clear_cmds();
                end
            endcase
            chk_n++; if (pc !== m_pc) $display("FAIL rnd%0d_pc op=%0d got=%h want=%h", n, sel, pc, m_pc); else pass_n++;
            chk_n++; if (ir !== m_ir) $display("FAIL rnd%0d_ir op=%0d got=%h want=%h", n, sel, ir, m_ir); else pass_n++;
            chk_n++; if (fault !== m_fault || busy !== 1'b0) $display("FAIL rnd%0d_status op=%0d fault=%b busy=%b want %b/0", n, sel, fault, busy, m_fault); else pass_n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_wait_state();
        test_branches();
        test_timeout();
        test_cmd_while_busy();
        test_pc_rst_mid_fetch();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
